// File: rtl/full_adder_dataflow_core_if.sv
// rtl/full_adder_dataflow_core_if.sv - operand/result bundle for full_adder_dataflow_core
interface full_adder_dataflow_core_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic [WIDTH-1:0] sum_q;
  logic             carry_out_q;
  logic             out_valid;
  logic             overflow_q;

  modport master (
    output a, b, carry_in, in_valid,
    input  sum, carry_out, sum_q, carry_out_q, out_valid, overflow_q
  );

  modport slave (
    input  a, b, carry_in, in_valid,
    output sum, carry_out, sum_q, carry_out_q, out_valid, overflow_q
  );
endinterface

// File: rtl/full_adder_dataflow_core.sv
// rtl/full_adder_dataflow_core.sv - ripple-carry adder with combinational and registered results
// Optional signed-overflow flag enabled by FULL_ADDER_DATAFLOW_OVF_EN.
module full_adder_dataflow_core #(
  parameter int WIDTH = 1
) (
  input logic                      clk,
  input logic                      rst,
  full_adder_dataflow_core_if.slave bus
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  // Bitwise full-adder chain; X on any input propagates naturally.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = bus.carry_in;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]   = bus.a[i] ^ bus.b[i] ^ c[i];
      c[i+1] = (bus.a[i] & bus.b[i]) | (bus.a[i] & c[i]) | (bus.b[i] & c[i]);
    end
  end

  assign bus.sum       = s;
  assign bus.carry_out = c[WIDTH];

  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             valid_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r   <= '0;
      carry_r <= 1'b0;
      valid_r <= 1'b0;
    end else if (bus.in_valid) begin
      sum_r   <= s;
      carry_r <= c[WIDTH];
      valid_r <= 1'b1;
    end else begin
      valid_r <= 1'b0;
    end
  end

  assign bus.sum_q       = sum_r;
  assign bus.carry_out_q = carry_r;
  assign bus.out_valid   = valid_r;

`ifdef FULL_ADDER_DATAFLOW_OVF_EN
  logic ovf;
  logic ovf_r;

  assign ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (s[WIDTH-1] != bus.a[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (bus.in_valid) begin
      ovf_r <= ovf;
    end
  end

  assign bus.overflow_q = ovf_r;
`else
  assign bus.overflow_q = 1'b0;
`endif

endmodule

// File: tb/tb_full_adder_dataflow_core.sv
// tb/tb_full_adder_dataflow_core.sv - directed self-checking bench for full_adder_dataflow_core
module tb_full_adder_dataflow_core;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

`ifdef FULL_ADDER_DATAFLOW_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  full_adder_dataflow_core_if #(.WIDTH(8)) bus8 ();
  full_adder_dataflow_core_if #(.WIDTH(1)) bus1 ();

  full_adder_dataflow_core #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  full_adder_dataflow_core #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic v);
    bus8.a        = a;
    bus8.b        = b;
    bus8.carry_in = ci;
    bus8.in_valid = v;
  endtask

  initial begin
    logic [7:0] sum_tab;
    logic [7:0] co_tab;
    logic [2:0] vec;
    errors  = 0;
    checks  = 0;
    sum_tab = 8'b1001_0110;
    co_tab  = 8'b1110_1000;

    rst = 1'b1;
    drive8(8'h00, 8'h00, 1'b0, 1'b0);
    bus1.a        = 1'b0;
    bus1.b        = 1'b0;
    bus1.carry_in = 1'b0;
    bus1.in_valid = 1'b0;
    tick();
    check("rst_sum_q", bus8.sum_q, 0);
    check("rst_carry_q", bus8.carry_out_q, 0);
    check("rst_out_valid", bus8.out_valid, 0);
    check("rst_overflow_q", bus8.overflow_q, 0);
    rst = 1'b0;

    // WIDTH=1 truth table, input order {a,b,carry_in}
    for (int i = 0; i < 8; i++) begin
      vec           = i[2:0];
      bus1.a        = vec[2];
      bus1.b        = vec[1];
      bus1.carry_in = vec[0];
      #1;
      check($sformatf("w1_sum_%0d", i), bus1.sum, sum_tab[i]);
      check($sformatf("w1_co_%0d", i), bus1.carry_out, co_tab[i]);
    end

    drive8(8'hFF, 8'h00, 1'b1, 1'b0);
    #1;
    check("ff_00_1_sum", bus8.sum, 8'h00);
    check("ff_00_1_co", bus8.carry_out, 1);
    drive8(8'hFF, 8'hFF, 1'b1, 1'b0);
    #1;
    check("ff_ff_1_sum", bus8.sum, 8'hFF);
    check("ff_ff_1_co", bus8.carry_out, 1);
    drive8(8'hA5, 8'h5A, 1'b1, 1'b0);
    #1;
    check("a5_5a_1_sum", bus8.sum, 8'h00);
    check("a5_5a_1_co", bus8.carry_out, 1);

    drive8(8'h12, 8'h34, 1'b0, 1'b1);
    tick();
    check("cap_sum_q", bus8.sum_q, 8'h46);
    check("cap_carry_q", bus8.carry_out_q, 0);
    check("cap_out_valid", bus8.out_valid, 1);
    check("cap_overflow_q", bus8.overflow_q, 0);
    drive8(8'h99, 8'h99, 1'b0, 1'b0);
    tick();
    check("idle_out_valid", bus8.out_valid, 0);
    check("idle_sum_q", bus8.sum_q, 8'h46);

    drive8(8'h80, 8'h80, 1'b0, 1'b1);
    tick();
    check("neg_sum_q", bus8.sum_q, 8'h00);
    check("neg_carry_q", bus8.carry_out_q, 1);
    check("neg_overflow_q", bus8.overflow_q, OVF_ON);

    drive8(8'h7F, 8'h01, 1'b0, 1'b1);
    #1;
    check("ovf_sum", bus8.sum, 8'h80);
    tick();
    check("ovf_sum_q", bus8.sum_q, 8'h80);
    check("ovf_carry_q", bus8.carry_out_q, 0);
    check("ovf_overflow_q", bus8.overflow_q, OVF_ON);
    check("ovf_out_valid", bus8.out_valid, 1);

    // Reset wins over a simultaneous capture
    rst = 1'b1;
    drive8(8'h01, 8'h01, 1'b0, 1'b1);
    #1;
    check("rstv_sum_pre", bus8.sum, 8'h02);
    tick();
    check("rstv_sum_q", bus8.sum_q, 0);
    check("rstv_carry_q", bus8.carry_out_q, 0);
    check("rstv_out_valid", bus8.out_valid, 0);
    check("rstv_overflow_q", bus8.overflow_q, 0);
    check("rstv_sum_post", bus8.sum, 8'h02);
    rst = 1'b0;
    drive8(8'h01, 8'h01, 1'b0, 1'b0);
    tick();
    check("post_rst_out_valid", bus8.out_valid, 0);
    check("post_rst_sum_q", bus8.sum_q, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/full_adder_dataflow_core.md
FULL_ADDER_DATAFLOW_CORE -- requirements
Module: full_adder_dataflow

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the operand width in bits (legal range 1..64).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all registers update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port a, input, WIDTH bits: addend A.
REQ-005 The block SHALL have port b, input, WIDTH bits: addend B.
REQ-006 The block SHALL have port carry_in, input, 1 bit: carry into bit 0.
REQ-007 The block SHALL have port in_valid, input, 1 bit: qualifies a/b/carry_in for the registered path.
REQ-008 The block SHALL have port sum, output, WIDTH bits: combinational sum.
REQ-009 The block SHALL have port carry_out, output, 1 bit: combinational carry out of the MSB.
REQ-010 The block SHALL have port sum_q, output, WIDTH bits: registered sum.
REQ-011 The block SHALL have port carry_out_q, output, 1 bit: registered carry out.
REQ-012 The block SHALL have port out_valid, output, 1 bit: registered outputs hold a fresh result this cycle.
REQ-013 The block SHALL have port overflow_q, output, 1 bit: registered signed-overflow flag (see Configuration).

Function
REQ-014 The combinational path SHALL be pure dataflow, per bit i: s[i] = a[i] ^ b[i] ^ c[i]; c[i+1] = majority(a[i], b[i], c[i]); c[0] = carry_in.
REQ-015 {carry_out, sum} SHALL equal a + b + carry_in, computed modulo 2^(WIDTH+1), with zero clock latency.
REQ-016 sum and carry_out SHALL be independent of clk, rst and in_valid, and SHALL settle within the same delta step as input changes.
REQ-017 On a rising edge with rst=0 and in_valid=1, sum_q/carry_out_q/overflow_q SHALL capture the current combinational results, and out_valid SHALL be 1 in the following cycle (latency 1).
REQ-018 On a rising edge with rst=0 and in_valid=0, sum_q/carry_out_q/overflow_q SHALL hold their values and out_valid SHALL go to 0.
REQ-019 Wrap-around: all-ones + all-ones + 1 SHALL give sum = all-ones, carry_out = 1; no saturation.
REQ-020 X/Z on any input bit SHALL be allowed to propagate; no masking logic.

Reset
REQ-021 On a rising edge with rst=1, sum_q, carry_out_q, overflow_q and out_valid SHALL all become 0.
REQ-022 rst SHALL take priority over in_valid in the same cycle; a result presented during reset SHALL be discarded.
REQ-023 Reset SHALL NOT affect the combinational outputs sum and carry_out.

Configuration
REQ-024 With macro FULL_ADDER_DATAFLOW_OVF_EN defined, overflow_q SHALL register (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]) when capturing.
REQ-025 Without FULL_ADDER_DATAFLOW_OVF_EN, overflow_q SHALL be tied to constant 0, no overflow logic SHALL be synthesized, and all other ports SHALL be unchanged.

Verification
REQ-026 For WIDTH=1, apply all 8 {a,b,carry_in} combinations 000..111 at 1-time-unit steps, no clock -> sum = 0,1,1,0,1,0,0,1 and carry_out = 0,0,0,1,0,1,1,1.
REQ-027 For WIDTH=8, a=8'hFF, b=8'h00, carry_in=1 -> sum=8'h00, carry_out=1; a=8'hFF, b=8'hFF, carry_in=1 -> sum=8'hFF, carry_out=1.
REQ-028 For WIDTH=8, in_valid=1 for one edge with a=8'h12, b=8'h34, carry_in=0 -> next cycle sum_q=8'h46, carry_out_q=0, out_valid=1; following idle cycle -> out_valid=0, sum_q still 8'h46.
REQ-029 Assert rst and in_valid together with a=8'h01, b=8'h01 -> after the edge sum_q=0, carry_out_q=0, out_valid=0, overflow_q=0; sum=8'h02 throughout.
REQ-030 For WIDTH=8 with FULL_ADDER_DATAFLOW_OVF_EN, capture a=8'h7F, b=8'h01, carry_in=0 -> overflow_q=1, sum_q=8'h80; without the macro, overflow_q=0.
